// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor slice.
//   - state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   - cnt_width : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must index bits 0..width-1; guard against a zero-width
  // counter for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fa.sv
// ----------------------------------------------------------------------------
// Gate_FA
//   Single-bit gate-level full adder.
//   Ports:
//     a, b   : input  operand bits
//     c_in   : input  carry in
//     sum    : output a ^ b ^ c_in
//     c_out  : output majority(a, b, c_in)
// ----------------------------------------------------------------------------
module Gate_FA (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic ab_x;

  assign ab_x  = a ^ b;
  assign sum   = ab_x ^ c_in;
  // Majority expressed with the shared half-sum term.
  assign c_out = (a & b) | (ab_x & c_in);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor. Computes diff = a - b over WIDTH
//   clock cycles, LSB first, with a single full-adder cell fed ~b and a carry
//   seeded to 1. Start/done handshake; results hold until the next operation
//   completes.
//   Parameters:
//     WIDTH      : operand/result width (>= 2)
//   Ports:
//     clk        : input  clock, rising edge
//     rst        : input  synchronous active-high reset
//     start      : input  request, sampled only in IDLE
//     a, b       : input  minuend / subtrahend, captured on accepted start
//     busy       : output high while shifting
//     done       : output one-cycle pulse when results become valid
//     diff       : output a - b mod 2^WIDTH
//     borrow_out : output 1 when unsigned a < b
//     overflow   : output signed overflow of the subtraction
// ----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the upper WIDTH-1 result bits; the newest sum bit completes it.
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  Gate_FA FA0 (
    .a     (a_sh[0]),
    .b     (~b_sh[0]),
    .c_in  (carry),
    .sum   (s),
    .c_out (c_nxt)
  );

  // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at
  // the LSB.
  assign res_nxt = {s, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            // Carry of 1 plus inverted b forms the two's-complement negation.
            carry  <= 1'b1;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt[WIDTH-1:1];
          carry  <= c_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the MSB step, carry is the carry into the MSB and c_nxt the
            // carry out; their XOR is signed overflow.
            diff       <= res_nxt;
            borrow_out <= ~c_nxt;
            overflow   <= carry ^ c_nxt;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b, diff;
  logic       busy, done, borrow_out, overflow;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, borrow8, ovf8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(borrow8), .overflow(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Golden arithmetic model of w-bit a - b.
  function automatic void model(input int w, input int av, input int bv,
                                output int ed, output int eb, output int eo);
    int sa, sb, sd;
    ed = (av - bv) & ((1 << w) - 1);
    eb = (av < bv) ? 1 : 0;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sd = sa - sb;
    eo = (sd > (1 << (w - 1)) - 1 || sd < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  // Start one 4-bit op; returns at the negedge of busy cycle 1, with the
  // operand inputs scrambled to prove they were captured.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av;
    b = bv + 4'd5;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ed,
                             input logic eb, input logic eo);
    for (int k = 1; k <= 4; k++) begin
      check({name, "_busy"}, busy, 1);
      check({name, "_nodone"}, done, 0);
      @(negedge clk);
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy_lo"}, busy, 0);
    check({name, "_diff"}, diff, ed);
    check({name, "_borrow"}, borrow_out, eb);
    check({name, "_ovf"}, overflow, eo);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_diff_hold"}, diff, ed);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [3:0] opa[3];
    logic [3:0] opb[3];
    int ed, eb, eo, lat;
    logic [7:0] ra, rb;

    vecs[0] = '{4'h7, 4'h3, 4'h4, 1'b0, 1'b0, "v7m3"};
    vecs[1] = '{4'h3, 4'h5, 4'hE, 1'b1, 1'b0, "v3m5"};
    vecs[2] = '{4'h8, 4'h1, 4'h7, 1'b0, 1'b1, "v8m1"};
    vecs[3] = '{4'h7, 4'hF, 4'h8, 1'b1, 1'b1, "v7mF"};
    vecs[4] = '{4'h9, 4'h9, 4'h0, 1'b0, 1'b0, "v9m9"};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, "v0m0"};
    vecs[6] = '{4'hF, 4'h0, 4'hF, 1'b0, 1'b0, "vFm0"};
    vecs[7] = '{4'h0, 4'h1, 4'hF, 1'b1, 1'b0, "v0m1"};
    vecs[8] = '{4'h0, 4'h8, 4'h8, 1'b1, 1'b1, "v0m8"};
    vecs[9] = '{4'h5, 4'h2, 4'h3, 1'b0, 1'b0, "v5m2"};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_diff8", diff8, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
    end

    // start held high with operands changing every cycle
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check("hold_done", done, (n % 6 == 5) ? 1 : 0);
        if (n % 6 == 5) begin
          model(4, int'(opa[n/6]), int'(opb[n/6]), ed, eb, eo);
          check("hold_diff", diff, ed);
          check("hold_borrow", borrow_out, eb);
          check("hold_ovf", overflow, eo);
        end
      end
      start = 1'b1;
      a = 4'(n * 3 + 1);
      b = 4'(n * 7 + 2);
      if (n % 6 == 0) begin
        opa[n/6] = a;
        opb[n/6] = b;
      end
    end
    start = 1'b0;

    // reset in the second SHIFT cycle aborts the op
    applyStimulus(4'h3, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    for (int k = 0; k < 6; k++) begin
      check("abort_nodone", done, 0);
      @(negedge clk);
    end
    applyStimulus(4'h9, 4'h9);
    checkOutput("post_abort", 4'h0, 1'b0, 1'b0);

    // 8-bit instance
    op8(8'h00, 8'hFF, lat);
    check("w8_latency", lat, 9);
    check("w8_diff", diff8, 8'h01);
    check("w8_borrow", borrow8, 1);
    check("w8_ovf", ovf8, 0);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, lat);
      model(8, int'(ra), int'(rb), ed, eb, eo);
      check("rand_done", done8, 1);
      check("rand_diff", diff8, ed);
      check("rand_borrow", borrow8, eb);
      check("rand_ovf", ovf8, eo);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
